lc3_decode_stage: RTL

Registered LC-3 decode stage: the responder on the decode_in interface. It accepts `instruction`/`npc_in` qualified by `enable_decode` and produces the registered instruction, next-PC, and execute, writeback and memory control words consumed by the execute stage and observed by the decode_out agent. It sits between fetch and execute and is the DUT behind the decode_in and decode_out UVMF environment.

---
 rtl/lc3_decode_stage.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/lc3_decode_stage.sv
// -----------------------------------------------------------------------------
// lc3_decode_stage
//
// Registered LC-3 decode stage sitting between fetch and execute. The opcode
// in instruction[15:12] is decoded combinationally into execute, writeback and
// memory control words. The decoded words, the instruction and its next-PC are
// captured on every rising clock edge where enable_decode is high.
//
// Handshake: enable_decode acts as a valid with no ready. The stage has no
// backpressure, so every edge with enable_decode=1 is an accept. decode_valid
// is high during exactly the cycle after an accepting edge. It stays high
// across back-to-back accepts. The execute stage must consume every such
// cycle.
//
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN
//   When defined, an illegal_op output flags opcodes 1000 (RTI) and
//   1101 (reserved). Those instructions do not advance decode_count.
//   When undefined, the port is absent and those opcodes decode to all-zero
//   controls and are counted like any other instruction.
//
// Ports
//   clock         in   1  rising-edge clock
//   reset         in   1  asynchronous active-low reset
//   enable_decode in   1  accept instruction/npc_in on this edge
//   instruction   in  16  LC-3 instruction word
//   npc_in        in  16  PC+1 of the instruction
//   ir            out 16  registered instruction
//   npc_out       out 16  registered npc_in
//   e_control     out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   w_control     out  2  00 ALU, 01 memory data, 10 computed PC (LEA)
//   mem_control   out  1  1 = indirect access (LDI/STI)
//   decode_valid  out  1  high for the cycle after each accept
//   decode_count  out 16  accepted-instruction counter (wraps)
//   illegal_op    out  1  only with DECODE_ILLEGAL_TRAP_EN
// -----------------------------------------------------------------------------
module lc3_decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] instruction,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  e_control,
  output logic [1:0]  w_control,
  output logic        mem_control,
  output logic        decode_valid,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic        illegal_op,
`endif
  output logic [15:0] decode_count
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;

  logic [3:0] opcode;
  logic [1:0] alu_sel;
  logic [1:0] pc_sel1;
  logic       pc_sel2;
  logic       op2_sel;
  logic [1:0] w_next;
  logic       mem_next;
  logic       illegal_next;
  logic       count_en;

  assign opcode = instruction[15:12];

  // Combinational decode; every field defaults to 0 so unused fields stay 0.
  always_comb begin
    alu_sel      = 2'b00;
    pc_sel1      = 2'b00;
    pc_sel2      = 1'b0;
    op2_sel      = 1'b0;
    w_next       = 2'b00;
    mem_next     = 1'b0;
    illegal_next = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_sel = 2'b00;
        op2_sel = ~instruction[5];  // bit 5 clear selects the register operand
      end
      OP_AND: begin
        alu_sel = 2'b01;
        op2_sel = ~instruction[5];
      end
      OP_NOT: begin
        alu_sel = 2'b10;
        op2_sel = 1'b1;
      end
      OP_BR: begin
        pc_sel1 = 2'b10;
        pc_sel2 = 1'b1;
      end
      OP_JMP: begin
        pc_sel1 = 2'b00;
        pc_sel2 = 1'b0;
      end
      OP_LD: begin
        pc_sel1 = 2'b10;
        pc_sel2 = 1'b1;
        w_next  = 2'b01;
      end
      OP_LDI: begin
        pc_sel1  = 2'b10;
        pc_sel2  = 1'b1;
        w_next   = 2'b01;
        mem_next = 1'b1;
      end
      OP_LDR: begin
        pc_sel1 = 2'b01;
        pc_sel2 = 1'b0;
        w_next  = 2'b01;
      end
      OP_LEA: begin
        pc_sel1 = 2'b10;
        pc_sel2 = 1'b1;
        w_next  = 2'b10;
      end
      OP_ST: begin
        pc_sel1 = 2'b10;
        pc_sel2 = 1'b1;
      end
      OP_STI: begin
        pc_sel1  = 2'b10;
        pc_sel2  = 1'b1;
        mem_next = 1'b1;
      end
      OP_STR: begin
        pc_sel1 = 2'b01;
        pc_sel2 = 1'b0;
      end
      OP_RTI, OP_RES: begin
        illegal_next = 1'b1;
      end
      default: begin
        // JSR and TRAP: all controls stay 0
      end
    endcase
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign count_en = enable_decode & ~illegal_next;
`else
  assign count_en = enable_decode;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ir           <= 16'h0000;
      npc_out      <= 16'h0000;
      e_control    <= 6'b000000;
      w_control    <= 2'b00;
      mem_control  <= 1'b0;
      decode_valid <= 1'b0;
    end else begin
      decode_valid <= enable_decode;
      if (enable_decode) begin
        ir          <= instruction;
        npc_out     <= npc_in;
        e_control   <= {alu_sel, pc_sel1, pc_sel2, op2_sel};
        w_control   <= w_next;
        mem_control <= mem_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      decode_count <= 16'h0000;
    end else if (count_en) begin
      decode_count <= decode_count + 16'h0001;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_op <= 1'b0;
    end else if (enable_decode) begin
      illegal_op <= illegal_next;
    end
  end
`else
  // illegal_next only feeds the optional port and counter gating.
  logic unused_illegal;
  assign unused_illegal = illegal_next;
`endif

endmodule
